// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response bundle between core and imem.
// master = processor side, slave = responder side.
interface imem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        fault;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata,
    input  fault
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata,
    output fault
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory with a program load port.
// Ports: clock, reset (async, active-low), bus (fetch slave), ld_en/ld_addr/ld_data.
// Option: define IMEM_FAULT_EN to flag misaligned / out-of-range fetches.
module imem_responder #(
  parameter int WORDS   = 64,
  parameter int LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  imem_responder_if.slave          bus,
  input  logic                     ld_en,
  input  logic [$clog2(WORDS)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;

  logic [31:0]   mem_q [WORDS];
  logic [IW-1:0] widx;
  logic          bad;
  logic          ld_we;

  assign widx = addr_q[IW+1:2];

`ifdef IMEM_FAULT_EN
  assign bad = (addr_q[1:0] != 2'b00)
            || (addr_q >= 32'(4 * WORDS));
`else
  // Byte offset and upper bits carry no meaning here:
  // the index wraps modulo WORDS.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[31:IW+2], addr_q[1:0]};
  assign bad = 1'b0;
`endif

  // Loads are blocked while the block is held in reset.
  assign ld_we = ld_en && reset;

  // Program storage is never cleared by reset.
  always_ff @(posedge clock) begin
    if (ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          cnt_d   = CW'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Reads the pre-edge word, so a same-edge
          // load is not seen by this response.
          rdata_d = bad ? 32'h0 : mem_q[widx];
          fault_d = bad;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.rvalid = (state_q == RESP);
  assign bus.rdata  = rdata_q;
  assign bus.fault  = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed + randomized bench for imem_responder.
// Two instances (LATENCY 2 and 1) share clock, reset and the load port.
module tb_imem_responder;

  localparam int WORDS = 64;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();

  imem_responder #(.WORDS(WORDS), .LATENCY(LAT)) dut0 (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus0),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  imem_responder #(.WORDS(WORDS), .LATENCY(1)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus1),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m [WORDS];
  logic [31:0] last0;
  logic [31:0] last1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {fault, rdata} for a fetch of byte address a.
  function automatic logic [32:0] model_resp(input logic [31:0] a);
`ifdef IMEM_FAULT_EN
    if ((a % 4) != 0 || a >= 32'(4 * WORDS)) return {1'b1, 32'h0};
`endif
    return {1'b0, m[int'((a / 4) % WORDS)]};
  endfunction

  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clock);
    ld_en   = 1'b1;
    ld_addr = 6'(idx);
    ld_data = d;
    m[idx]  = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // One fetch on dut0. Optional load driven in cycle 'off' after the
  // request cycle; it lands on the following edge. Memory is snapshotted
  // for the response just before a load driven in cycle LAT.
  task automatic fetch0(input logic [31:0] a, input bit do_ld,
                        input int off, input int li,
                        input logic [31:0] ld);
    logic [32:0] exp;
    exp = '0;
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge clock);
      if (c == 0) begin
        check("ready_idle", 32'(bus0.ready), 32'd1);
      end else begin
        check("ready_busy", 32'(bus0.ready), 32'd0);
        check("rvalid", 32'(bus0.rvalid), 32'(c == LAT + 1));
        if (c == LAT + 1) begin
          check("rdata", bus0.rdata, exp[31:0]);
          check("fault", 32'(bus0.fault), 32'(exp[32]));
          last0 = exp[31:0];
        end else begin
          check("rdata_hold", bus0.rdata, last0);
        end
      end
      if (c == LAT) exp = model_resp(a);
      if (c == 0) begin
        bus0.req  = 1'b1;
        bus0.addr = a;
      end else if (c <= LAT) begin
        bus0.req  = 1'($urandom_range(0, 1));
        bus0.addr = $urandom;
      end else begin
        bus0.req = 1'b0;
      end
      ld_en = do_ld && (c == off) && (c <= LAT);
      if (ld_en) begin
        ld_addr = 6'(li);
        ld_data = ld;
        m[li]   = ld;
      end
    end
  endtask

  task automatic fetch1(input logic [31:0] a);
    logic [32:0] exp;
    @(negedge clock);
    check("l1_ready_idle", 32'(bus1.ready), 32'd1);
    bus1.req  = 1'b1;
    bus1.addr = a;
    @(negedge clock);
    check("l1_ready_busy", 32'(bus1.ready), 32'd0);
    check("l1_rvalid_early", 32'(bus1.rvalid), 32'd0);
    check("l1_rdata_hold", bus1.rdata, last1);
    exp = model_resp(a);
    bus1.req = 1'b0;
    @(negedge clock);
    check("l1_rvalid", 32'(bus1.rvalid), 32'd1);
    check("l1_rdata", bus1.rdata, exp[31:0]);
    check("l1_fault", 32'(bus1.fault), 32'(exp[32]));
    last1 = exp[31:0];
  endtask

  initial begin
    logic [31:0] a;
    int          li;
    reset     = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    bus0.req  = 1'b0;
    bus0.addr = '0;
    bus1.req  = 1'b0;
    bus1.addr = '0;
    last0     = '0;
    last1     = '0;

    #2;
    check("rst_ready", 32'(bus0.ready), 32'd1);
    check("rst_rvalid", 32'(bus0.rvalid), 32'd0);
    check("rst_rdata", bus0.rdata, 32'h0);
    check("rst_fault", 32'(bus0.fault), 32'd0);
    check("rst_l1_ready", 32'(bus1.ready), 32'd1);

    @(negedge clock);
    reset = 1'b1;

    // Fill the whole memory so the model never reads unknowns.
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clock);
      ld_en   = 1'b1;
      ld_addr = 6'(i);
      ld_data = $urandom;
      m[i]    = ld_data;
    end
    @(negedge clock);
    ld_en = 1'b0;

    // Basic fetch of a loaded word.
    load(3, 32'h012A4020);
    fetch0(32'h0000000C, 1'b0, 0, 0, 32'h0);

    // Continuous request: one pulse every LAT+2 cycles.
    for (int n = 0; n < 3 * (LAT + 2); n++) begin
      @(negedge clock);
      check("cont_ready", 32'(bus0.ready), 32'(n % (LAT + 2) == 0));
      check("cont_rvalid", 32'(bus0.rvalid),
            32'(n % (LAT + 2) == LAT + 1));
      if (n % (LAT + 2) == LAT + 1) begin
        check("cont_rdata", bus0.rdata, m[0]);
        last0 = m[0];
      end
      bus0.req  = 1'b1;
      bus0.addr = 32'h0;
    end
    @(negedge clock);
    bus0.req = 1'b0;

    // Misaligned and out-of-range addresses.
    fetch0(32'h0000000E, 1'b0, 0, 0, 32'h0);
    fetch0(32'h00000100, 1'b0, 0, 0, 32'h0);

    // Load on the WAIT edge before the read: new data.
    load(5, 32'h11111111);
    fetch0(32'h00000014, 1'b1, LAT - 1, 5, 32'hDEADBEEF);
    // Load on the read edge itself: old data.
    load(5, 32'h22222222);
    fetch0(32'h00000014, 1'b1, LAT, 5, 32'hDEADBEEF);
    fetch0(32'h00000014, 1'b0, 0, 0, 32'h0);

    // Reset pulse in the middle of WAIT.
    @(negedge clock);
    bus0.req  = 1'b1;
    bus0.addr = 32'h0000000C;
    @(negedge clock);
    bus0.req = 1'b0;
    #1;
    reset   = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 6'd3;
    ld_data = 32'hBAD0BAD0;
    #1;
    check("mid_rst_ready", 32'(bus0.ready), 32'd1);
    check("mid_rst_rvalid", 32'(bus0.rvalid), 32'd0);
    check("mid_rst_rdata", bus0.rdata, 32'h0);
    check("mid_rst_fault", 32'(bus0.fault), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    ld_en = 1'b0;
    last0 = '0;
    last1 = '0;
    for (int n = 0; n < LAT + 2; n++) begin
      @(negedge clock);
      check("post_rst_rvalid", 32'(bus0.rvalid), 32'd0);
      check("post_rst_rdata", bus0.rdata, 32'h0);
    end
    fetch0(32'h0000000C, 1'b0, 0, 0, 32'h0);

    // LATENCY=1 instance.
    fetch1(32'h0000000C);
    fetch1(32'h00000014);
    fetch1(32'h00000100);

    // Randomized fetches with colliding and non-colliding loads.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 4 * WORDS - 1));
      if ($urandom_range(0, 1) == 1) li = int'((a / 4) % WORDS);
      else li = int'($urandom_range(0, WORDS - 1));
      fetch0(a, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, LAT)), li, $urandom);
    end
    for (int k = 0; k < 10; k++) begin
      fetch1(32'($urandom_range(0, 4 * WORDS + 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter WORDS, default 64, meaning instruction memory depth in 32-bit words (power of two, at least 2).
REQ-002 Parameter LATENCY, default 2, meaning cycles from request acceptance to response (at least 1).
REQ-003 Port clock  input  1  meaning rising-edge clock.
REQ-004 Port reset  input  1  meaning asynchronous, active-low reset (0 = reset).
REQ-005 Port req  input  1  meaning fetch request from the processor.
REQ-006 Port addr  input  32  meaning fetch byte address (the PC).
REQ-007 Port ready  output  1  meaning the responder can accept a request this cycle.
REQ-008 Port rvalid  output  1  meaning rdata and fault are valid this cycle.
REQ-009 Port rdata  output  32  meaning the fetched instruction word.
REQ-010 Port fault  output  1  meaning the fetch address was illegal (see Configuration).
REQ-011 Port ld_en  input  1  meaning write ld_data into memory this cycle.
REQ-012 Port ld_addr  input  log2(WORDS)  meaning word index for the load port.
REQ-013 Port ld_data  input  32  meaning the program word to load.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT and RESP, with ready=1 only in IDLE.
REQ-015 In IDLE with req=1, the block SHALL latch addr, load the counter with LATENCY-1, and go to WAIT; with req=0 it SHALL stay in IDLE.
REQ-016 In WAIT, the block SHALL decrement the counter each cycle, and on the edge where the counter is 0 it SHALL register mem[addr[log2(WORDS)+1:2]] into rdata and go to RESP.
REQ-017 In RESP, rvalid SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE; rvalid SHALL be 0 in every other state.
REQ-018 Response latency SHALL be LATENCY+1 cycles from the accepting edge, giving a maximum throughput of one request per LATENCY+2 cycles.
REQ-019 req while ready=0 SHALL be ignored and not queued.
REQ-020 rdata and fault SHALL hold their values from the last response until the next response.
REQ-021 The load port SHALL write mem[ld_addr] on any rising edge with ld_en=1, in any state.
REQ-022 When a load targets the word being read on the same edge as the read in REQ-016, the response SHALL return the old word; a load on any earlier edge SHALL be visible in the response.
REQ-023 On a faulting fetch, rdata SHALL be 0x00000000 with fault=1.

Reset
REQ-024 With reset=0, the block SHALL immediately force state=IDLE, ready=1, rvalid=0, rdata=0, fault=0, counter=0, and the latched address to 0.
REQ-025 Reset asserted mid-fetch SHALL drop the pending request with no response; memory contents SHALL NOT be cleared by reset.
REQ-026 The load port SHALL be ignored while reset=0.

Configuration
REQ-027 Macro IMEM_FAULT_EN, when defined, SHALL set fault=1 on a response if addr[1:0]!=0 or addr>=4*WORDS.
REQ-028 Without IMEM_FAULT_EN, fault SHALL be tied to 0, addr[1:0] SHALL be ignored, and the word index SHALL wrap modulo WORDS (upper address bits discarded).

Verification
REQ-029 Defaults; load mem[3]=0x012A4020; req with addr=0x0C at cycle 0 -> ready=0 in cycles 1-3, rvalid=1 in cycle 3 only, rdata=0x012A4020, fault=0.
REQ-030 req held at 1 continuously with addr=0 -> exactly one rvalid pulse every 4 cycles, with ready=1 only in the cycle after each pulse.
REQ-031 IMEM_FAULT_EN; addr=0x0E, then addr=0x100 -> both responses give fault=1 and rdata=0; without the macro, addr=0x100 returns mem[0].
REQ-032 Request mem[5]; load mem[5]=0xDEADBEEF on the WAIT edge before the read -> new data returned; repeat with the load on the read edge -> old data returned.
REQ-033 Assert reset=0 mid-WAIT for half a cycle -> outputs go to reset values asynchronously, no rvalid afterwards, and mem[3] still reads 0x012A4020 on the next fetch.
REQ-034 LATENCY=1 -> rvalid appears 2 cycles after acceptance.
